lcd_text_buffer: RTL and testbench

- Character-stream front end that sits directly upstream of lcd_controller.
- Accepts single ASCII bytes (or control codes) over a valid/ready handshake.
- Maintains the 2x16 display image and drives it on row_1/row_2, which connect straight to lcd_controller's row_1/row_2.
- Handles cursor advance, backspace, newline, clear and scroll, so producers (keypad decoder, game logic) never manipulate 128-bit rows themselves.

---
 rtl/lcd_text_buffer.sv | 150 +++++++++++++++
 tb/tb_lcd_text_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: character-stream front end for lcd_controller.
// Holds the 2x16 display image and applies printable/control bytes to it.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   in_data/in_valid    character or control code, valid/ready handshake
//   in_ready            high when a byte can be accepted this cycle
//   row_1, row_2        display image, column 0 in the top byte
//   cursor              next write cell, 0-15 row 1, 16-31 row 2
//   busy                high while clearing or scrolling
//   changed             one-cycle pulse after the image was updated
module lcd_text_buffer #(
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter bit         SCROLL_EN  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] row_1,
    output logic [127:0] row_2,
    output logic [4:0]   cursor,
    output logic         busy,
    output logic         changed
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL
    } state_t;

    localparam logic [127:0] BLANK_ROW = {16{BLANK_CHAR}};

    state_t     state;
    logic [4:0] clr_idx;
    logic       xfer;
    logic       printable;
    logic [4:0] cur_dec;

    assign in_ready  = (state == IDLE) && !rst;
    assign xfer      = in_valid && in_ready;
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign cur_dec   = cursor - 5'd1;

    // Column 0 lives in the top byte, so the byte offset is (15 - col) = ~col.
    function automatic logic [127:0] put(
        input logic [127:0] row,
        input logic [3:0]   col,
        input logic [7:0]   ch
    );
        logic [127:0] r;
        r = row;
        r[{~col, 3'b000} +: 8] = ch;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            row_1   <= BLANK_ROW;
            row_2   <= BLANK_ROW;
            cursor  <= 5'd0;
            clr_idx <= 5'd0;
            state   <= IDLE;
            busy    <= 1'b0;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        unique case (1'b1)
                            printable: begin
                                if (cursor[4])
                                    row_2 <= put(row_2, cursor[3:0], in_data);
                                else
                                    row_1 <= put(row_1, cursor[3:0], in_data);
                                if (cursor != 5'd31) begin
                                    cursor  <= cursor + 5'd1;
                                    changed <= 1'b1;
                                end else if (SCROLL_EN) begin
                                    // changed is deferred to the scroll cycle
                                    state <= SCROLL;
                                    busy  <= 1'b1;
                                end else begin
                                    cursor  <= 5'd0;
                                    changed <= 1'b1;
                                end
                            end
                            (in_data == 8'h08): begin
                                if (cursor != 5'd0) begin
                                    cursor <= cur_dec;
                                    if (cur_dec[4])
                                        row_2 <= put(row_2, cur_dec[3:0], BLANK_CHAR);
                                    else
                                        row_1 <= put(row_1, cur_dec[3:0], BLANK_CHAR);
                                    changed <= 1'b1;
                                end
                            end
                            (in_data == 8'h0A): begin
                                // newline alone only moves the cursor
                                if (!cursor[4]) begin
                                    cursor <= 5'd16;
                                end else if (SCROLL_EN) begin
                                    state <= SCROLL;
                                    busy  <= 1'b1;
                                end else begin
                                    cursor <= 5'd0;
                                end
                            end
                            (in_data == 8'h0C): begin
                                clr_idx <= 5'd0;
                                state   <= CLEAR;
                                busy    <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                CLEAR: begin
                    if (clr_idx[4])
                        row_2 <= put(row_2, clr_idx[3:0], BLANK_CHAR);
                    else
                        row_1 <= put(row_1, clr_idx[3:0], BLANK_CHAR);
                    clr_idx <= clr_idx + 5'd1;
                    if (clr_idx == 5'd31) begin
                        cursor  <= 5'd0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        changed <= 1'b1;
                    end
                end
                SCROLL: begin
                    row_1   <= row_2;
                    row_2   <= BLANK_ROW;
                    cursor  <= 5'd16;
                    state   <= IDLE;
                    busy    <= 1'b0;
                    changed <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// tb_lcd_text_buffer: directed bench for lcd_text_buffer.
// Instance 1 scrolls on overflow, instance 0 wraps.
module tb_lcd_text_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         v [2];
    logic         rdy [2];
    logic [127:0] r1 [2];
    logic [127:0] r2 [2];
    logic [4:0]   cur [2];
    logic         bsy [2];
    logic         chg [2];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [127:0] r1;
        logic [127:0] r2;
        logic [4:0]   cur;
        logic         chg;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] mem [2][32];
    int         mcur [2];

    always #5 clk = ~clk;

    lcd_text_buffer #(.BLANK_CHAR(8'h20), .SCROLL_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v[0]),
        .in_ready(rdy[0]), .row_1(r1[0]), .row_2(r2[0]),
        .cursor(cur[0]), .busy(bsy[0]), .changed(chg[0])
    );

    lcd_text_buffer #(.BLANK_CHAR(8'h20), .SCROLL_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v[1]),
        .in_ready(rdy[1]), .row_1(r1[1]), .row_2(r2[1]),
        .cursor(cur[1]), .busy(bsy[1]), .changed(chg[1])
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack(input int k, input int base);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = mem[k][base+i];
        return r;
    endfunction

    task automatic model_reset(input int k);
        for (int i = 0; i < 32; i++) mem[k][i] = 8'h20;
        mcur[k] = 0;
    endtask

    task automatic model_scroll(input int k);
        for (int i = 0; i < 16; i++) begin
            mem[k][i]    = mem[k][i+16];
            mem[k][i+16] = 8'h20;
        end
        mcur[k] = 16;
    endtask

    task automatic model_step(input int k, input logic [7:0] ch,
                              output bit sc, output bit c);
        sc = 0;
        c  = 0;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            mem[k][mcur[k]] = ch;
            c = 1;
            if (mcur[k] < 31) mcur[k]++;
            else if (k == 1) begin model_scroll(k); sc = 1; end
            else mcur[k] = 0;
        end else if (ch == 8'h08) begin
            if (mcur[k] > 0) begin
                mcur[k]--;
                mem[k][mcur[k]] = 8'h20;
                c = 1;
            end
        end else if (ch == 8'h0A) begin
            if (mcur[k] < 16) mcur[k] = 16;
            else if (k == 1) begin model_scroll(k); sc = 1; c = 1; end
            else mcur[k] = 0;
        end
    endtask

    task automatic push_exp(input int k, input bit c);
        exp_t e;
        e.r1  = pack(k, 0);
        e.r2  = pack(k, 16);
        e.cur = mcur[k][4:0];
        e.chg = c;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int k, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, ".row_1"}, r1[k], e.r1);
        check({tag, ".row_2"}, r2[k], e.r2);
        check({tag, ".cursor"}, 128'(cur[k]), 128'(e.cur));
        check({tag, ".changed"}, 128'(chg[k]), 128'(e.chg));
        check({tag, ".busy"}, 128'(bsy[k]), 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rdy0_in_rst", 128'(rdy[0]), 128'(0));
        check("rdy1_in_rst", 128'(rdy[1]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check("rdy0_after_rst", 128'(rdy[0]), 128'(1));
        check("rdy1_after_rst", 128'(rdy[1]), 128'(1));
        push_exp(0, 0);
        pop_check(0, "rst0");
        push_exp(1, 0);
        pop_check(1, "rst1");
    endtask

    task automatic send(input int k, input logic [7:0] ch);
        bit sc, c;
        @(negedge clk);
        in_data = ch;
        v[k] = 1'b1;
        #1;
        check("send.in_ready", 128'(rdy[k]), 128'(1));
        @(posedge clk);
        #1;
        v[k] = 1'b0;
        model_step(k, ch, sc, c);
        if (sc) begin
            check("scroll.busy", 128'(bsy[k]), 128'(1));
            check("scroll.early_changed", 128'(chg[k]), 128'(0));
            @(posedge clk);
            #1;
        end
        push_exp(k, c);
        pop_check(k, $sformatf("send%0d_%h", k, ch));
    endtask

    initial begin
        int n;
        bit sc, c;
        v[0] = 1'b0;
        v[1] = 1'b0;
        model_reset(0);
        model_reset(1);
        repeat (2) @(posedge clk);
        do_reset();

        send(1, 8'h48); send(1, 8'h65); send(1, 8'h6C);
        send(1, 8'h6C); send(1, 8'h6F);
        check("hello.row_1", r1[1], 128'h48656C6C6F2020202020202020202020);
        send(1, 8'h0A);
        send(1, 8'h01);

        do_reset();
        for (int i = 0; i < 16; i++) send(1, 8'h41);
        send(1, 8'h42);
        check("ab.col16", 128'(r2[1][127:120]), 128'(8'h42));
        send(1, 8'h08);

        do_reset();
        for (int i = 0; i < 16; i++) send(1, 8'h41);
        for (int i = 0; i < 16; i++) send(1, 8'h43);
        check("scroll.row_1", r1[1], {16{8'h43}});
        for (int i = 0; i < 16; i++) send(0, 8'h41);
        for (int i = 0; i < 16; i++) send(0, 8'h43);
        check("wrap.cursor", 128'(cur[0]), 128'(0));

        @(negedge clk);
        in_data = 8'h0C;
        v[1] = 1'b1;
        @(posedge clk);
        #1;
        in_data = 8'h5A;
        n = 0;
        @(negedge clk);
        while (!rdy[1] && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("clear.ready_low_cycles", 128'(n), 128'(32));
        model_reset(1);
        push_exp(1, 1);
        pop_check(1, "clear_done");
        @(posedge clk);
        #1;
        v[1] = 1'b0;
        model_step(1, 8'h5A, sc, c);
        push_exp(1, c);
        pop_check(1, "after_clear_Z");

        @(negedge clk);
        in_data = 8'h0C;
        v[1] = 1'b1;
        @(posedge clk);
        #1;
        v[1] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midclear.busy", 128'(bsy[1]), 128'(1));
        do_reset();
        send(1, 8'h08);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
